// File: rtl/ysyx_25020047_pkg.sv
// rtl/ysyx_25020047_pkg.sv - shared state encoding, halt causes and inst_type constants for the NPC core
package ysyx_25020047_pkg;

   typedef enum logic [2:0] {
      ST_RST        = 3'd0,
      ST_FETCH_REQ  = 3'd1,
      ST_FETCH_WAIT = 3'd2,
      ST_EXEC       = 3'd3,
      ST_MEM_REQ    = 3'd4,
      ST_MEM_WAIT   = 3'd5,
      ST_WB         = 3'd6,
      ST_HALT       = 3'd7
   } state_t;

   localparam logic [1:0] HALT_NONE    = 2'b00;
   localparam logic [1:0] HALT_EBREAK  = 2'b01;
   localparam logic [1:0] HALT_ILLEGAL = 2'b10;
   localparam logic [1:0] HALT_BUSERR  = 2'b11;

   localparam logic [5:0] INST_R = 6'b000001;
   localparam logic [5:0] INST_I = 6'b000010;
   localparam logic [5:0] INST_S = 6'b000100;
   localparam logic [5:0] INST_B = 6'b001000;
   localparam logic [5:0] INST_U = 6'b010000;
   localparam logic [5:0] INST_J = 6'b100000;

   function automatic logic is_wait_state(state_t s);
      return s inside {ST_FETCH_REQ, ST_FETCH_WAIT, ST_MEM_REQ, ST_MEM_WAIT};
   endfunction

endpackage

// File: rtl/ysyx_25020047_exec_ctrl_if.sv
// rtl/ysyx_25020047_exec_ctrl_if.sv - IFU and LSU request/response handshakes seen by the sequencer
interface ysyx_25020047_exec_ctrl_if;

   logic ifu_req_valid;
   logic ifu_req_ready;
   logic ifu_resp_valid;
   logic ifu_resp_err;
   logic mem_req_valid;
   logic mem_req_we;
   logic mem_req_ready;
   logic mem_resp_valid;
   logic mem_resp_err;

   modport master (
      output ifu_req_valid, mem_req_valid, mem_req_we,
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_err,
      input  mem_req_ready, mem_resp_valid, mem_resp_err
   );

   modport slave (
      input  ifu_req_valid, mem_req_valid, mem_req_we,
      output ifu_req_ready, ifu_resp_valid, ifu_resp_err,
      output mem_req_ready, mem_resp_valid, mem_resp_err
   );

endinterface

// File: rtl/ysyx_25020047_watchdog.sv
// rtl/ysyx_25020047_watchdog.sv - saturating wait-cycle counter that flags a stuck bus handshake
module ysyx_25020047_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] LAST  = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != LIMIT) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Fires in the cycle whose increment would reach TIMEOUT, so the abort lands TIMEOUT cycles after entry.
   assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/ysyx_25020047_exec_ctrl.sv
// rtl/ysyx_25020047_exec_ctrl.sv - multi-cycle FETCH/EXEC/MEM/WB sequencer with halt and retire tracking
module ysyx_25020047_exec_ctrl
   import ysyx_25020047_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   ysyx_25020047_exec_ctrl_if.master  bus,
   output logic                       ex_valid,
   input  logic                       exu_reg_wen,
   input  logic                       exu_read,
   input  logic                       exu_write,
   input  logic                       exu_halt,
   input  logic                       exu_illegal,
   output logic                       rf_wen,
   output logic                       rf_wsel_mem,
   output logic                       pc_wen,
   output logic                       halted,
   output logic [1:0]                 halt_code,
   output logic [CNT_W-1:0]           inst_cnt
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_t     state, state_n;
   logic [1:0] code_n;
   logic       lat_wen, lat_rd, lat_wr;
   logic       wen_n, rd_n, wr_n;
   logic       bad_inst, retire;
   logic       wd_en, wd_clr, wd_expired;

   assign bad_inst = exu_illegal | (exu_read & exu_write);
   assign wen_n    = (state == ST_EXEC) ? exu_reg_wen : lat_wen;
   assign rd_n     = (state == ST_EXEC) ? exu_read    : lat_rd;
   assign wr_n     = (state == ST_EXEC) ? exu_write   : lat_wr;
   assign retire   = (state == ST_WB) || (state == ST_EXEC && !bad_inst && exu_halt);
   assign wd_en    = is_wait_state(state);
   assign wd_clr   = (state_n != state);

   always_comb begin
      state_n = state;
      code_n  = halt_code;
      case (state)
         ST_RST:        state_n = ST_FETCH_REQ;
         ST_FETCH_REQ:  if (bus.ifu_req_ready) state_n = ST_FETCH_WAIT;
         ST_FETCH_WAIT: begin
            if (bus.ifu_resp_valid) begin
               if (bus.ifu_resp_err) begin
                  state_n = ST_HALT;
                  code_n  = HALT_BUSERR;
               end else begin
                  state_n = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (bad_inst) begin
               state_n = ST_HALT;
               code_n  = HALT_ILLEGAL;
            end else if (exu_halt) begin
               state_n = ST_HALT;
               code_n  = HALT_EBREAK;
            end else if (exu_read | exu_write) begin
               state_n = ST_MEM_REQ;
            end else begin
               state_n = ST_WB;
            end
         end
         ST_MEM_REQ:    if (bus.mem_req_ready) state_n = ST_MEM_WAIT;
         ST_MEM_WAIT: begin
            if (bus.mem_resp_valid) begin
               if (bus.mem_resp_err) begin
                  state_n = ST_HALT;
                  code_n  = HALT_BUSERR;
               end else begin
                  state_n = ST_WB;
               end
            end
         end
         ST_WB:         state_n = ST_FETCH_REQ;
         ST_HALT:       state_n = ST_HALT;
         default:       state_n = ST_RST;
      endcase
      // A stuck wait aborts even if the handshake shows up in the same cycle.
      if (wd_expired) begin
         state_n = ST_HALT;
         code_n  = HALT_BUSERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_RST;
         lat_wen           <= 1'b0;
         lat_rd            <= 1'b0;
         lat_wr            <= 1'b0;
         bus.ifu_req_valid <= 1'b0;
         bus.mem_req_valid <= 1'b0;
         bus.mem_req_we    <= 1'b0;
         ex_valid          <= 1'b0;
         rf_wen            <= 1'b0;
         rf_wsel_mem       <= 1'b0;
         pc_wen            <= 1'b0;
         halted            <= 1'b0;
         halt_code         <= HALT_NONE;
         inst_cnt          <= '0;
      end else begin
         state             <= state_n;
         lat_wen           <= wen_n;
         lat_rd            <= rd_n;
         lat_wr            <= wr_n;
         bus.ifu_req_valid <= (state_n == ST_FETCH_REQ);
         bus.mem_req_valid <= (state_n == ST_MEM_REQ);
         bus.mem_req_we    <= (state_n == ST_MEM_REQ) && wr_n;
         ex_valid          <= (state_n == ST_EXEC);
         rf_wen            <= (state_n == ST_WB) && wen_n;
         rf_wsel_mem       <= (state_n == ST_WB) && rd_n;
         pc_wen            <= (state_n == ST_WB);
         halted            <= (state_n == ST_HALT);
         halt_code         <= code_n;
         if (retire) inst_cnt <= inst_cnt + CNT_W'(1);
      end
   end

   ysyx_25020047_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

endmodule
